// File: rtl/run_len_detector.sv
// Run-length detector: flags runs of run_len identical accepted bits, with polarity
// filtering, saturating run/hit counters and synchronous clear. RUN_LEN_DETECTOR_PULSE_EN makes out a match-entry pulse.
module run_len_detector #(
   parameter int CNT_W = 4,
   parameter int HIT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             in,
   input  logic             in_valid,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] run_len,
   output logic             out,
   output logic             out_bit,
   output logic [CNT_W-1:0] run_cnt,
   output logic [HIT_W-1:0] hit_cnt
);

   localparam logic [CNT_W-1:0] RUN_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] RUN_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] RUN_MAX  = {CNT_W{1'b1}};
   localparam logic [HIT_W-1:0] HIT_ZERO = {HIT_W{1'b0}};
   localparam logic [HIT_W-1:0] HIT_ONE  = {{(HIT_W-1){1'b0}}, 1'b1};
   localparam logic [HIT_W-1:0] HIT_MAX  = {HIT_W{1'b1}};

   logic             match_q, match_d;
   logic             out_bit_q, out_bit_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
   logic             pulse_q, pulse_d;

   logic [CNT_W-1:0] run_cnt_nxt_s;
   logic             polarity_ok_s;
   logic             match_nxt_s;
   logic             entry_s;

   // Candidate next run length and match decision for the sample on the input.
   always_comb begin
      run_cnt_nxt_s = RUN_ONE;
      if ((run_cnt_q != RUN_ZERO) && (in == out_bit_q)) begin
         if (run_cnt_q == RUN_MAX) begin
            run_cnt_nxt_s = RUN_MAX;
         end else begin
            run_cnt_nxt_s = run_cnt_q + RUN_ONE;
         end
      end else begin
         run_cnt_nxt_s = RUN_ONE;
      end

      case (mode)
         2'b00:   polarity_ok_s = 1'b1;
         2'b01:   polarity_ok_s = in;
         2'b10:   polarity_ok_s = ~in;
         default: polarity_ok_s = 1'b0;
      endcase

      match_nxt_s = (run_len != RUN_ZERO) && (run_cnt_nxt_s >= run_len) && polarity_ok_s;
      // Entry is tracked on the level flag so hit counting is build-independent.
      entry_s     = in_valid & ~clear & ~match_q & match_nxt_s;
   end

   // Next-state: clear wins, accepted samples update, otherwise everything holds.
   always_comb begin
      match_d   = match_q;
      out_bit_d = out_bit_q;
      run_cnt_d = run_cnt_q;
      hit_cnt_d = hit_cnt_q;
      pulse_d   = entry_s;
      if (clear) begin
         match_d   = 1'b0;
         out_bit_d = 1'b0;
         run_cnt_d = RUN_ZERO;
         hit_cnt_d = HIT_ZERO;
      end else if (in_valid) begin
         match_d   = match_nxt_s;
         out_bit_d = in;
         run_cnt_d = run_cnt_nxt_s;
         if (entry_s && (hit_cnt_q != HIT_MAX)) begin
            hit_cnt_d = hit_cnt_q + HIT_ONE;
         end else begin
            hit_cnt_d = hit_cnt_q;
         end
      end else begin
         match_d   = match_q;
         out_bit_d = out_bit_q;
         run_cnt_d = run_cnt_q;
         hit_cnt_d = hit_cnt_q;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         match_q   <= 1'b0;
         out_bit_q <= 1'b0;
         run_cnt_q <= RUN_ZERO;
         hit_cnt_q <= HIT_ZERO;
         pulse_q   <= 1'b0;
      end else begin
         match_q   <= match_d;
         out_bit_q <= out_bit_d;
         run_cnt_q <= run_cnt_d;
         hit_cnt_q <= hit_cnt_d;
         pulse_q   <= pulse_d;
      end
   end

`ifdef RUN_LEN_DETECTOR_PULSE_EN
   assign out = pulse_q;
   logic unused_match_s;
   assign unused_match_s = match_q;
`else
   assign out = match_q;
   logic unused_pulse_s;
   assign unused_pulse_s = pulse_q;
`endif
   assign out_bit = out_bit_q;
   assign run_cnt = run_cnt_q;
   assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_run_len_detector.sv
// Directed self-checking bench for run_len_detector (level and pulse builds).
module tb_run_len_detector;

`ifdef RUN_LEN_DETECTOR_PULSE_EN
   localparam bit PULSE = 1'b1;
`else
   localparam bit PULSE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_r = 1'b0;
   logic       clear_r = 1'b0;
   logic       in_r = 1'b0;
   logic       in_valid_r = 1'b0;
   logic [1:0] mode_r = 2'b00;
   logic [3:0] run_len_r = 4'd0;
   logic       out, out_bit;
   logic [3:0] run_cnt;
   logic [7:0] hit_cnt;
   logic       out2, out_bit2;
   logic [3:0] run_cnt2;
   logic [1:0] hit_cnt2;
   int         cmp_cnt = 0;
   int         fail_cnt = 0;

   always #5 clk = ~clk;

   run_len_detector #(.CNT_W(4), .HIT_W(8)) dut (
      .clk(clk), .reset(reset_r), .clear(clear_r), .in(in_r), .in_valid(in_valid_r),
      .mode(mode_r), .run_len(run_len_r), .out(out), .out_bit(out_bit),
      .run_cnt(run_cnt), .hit_cnt(hit_cnt));

   run_len_detector #(.CNT_W(4), .HIT_W(2)) dut_h2 (
      .clk(clk), .reset(reset_r), .clear(clear_r), .in(in_r), .in_valid(in_valid_r),
      .mode(mode_r), .run_len(run_len_r), .out(out2), .out_bit(out_bit2),
      .run_cnt(run_cnt2), .hit_cnt(hit_cnt2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic acc(input logic b);
      in_r = b;
      in_valid_r = 1'b1;
      tick();
      in_valid_r = 1'b0;
   endtask

   task automatic do_clear(input logic [1:0] m, input logic [3:0] rl);
      clear_r = 1'b1;
      tick();
      clear_r = 1'b0;
      mode_r = m;
      run_len_r = rl;
   endtask

   task automatic test_reset();
      reset_r = 1'b0;
      tick(); tick();
      reset_r = 1'b1;
      tick();
      cmp_cnt++;
      if (out !== 1'b0 || out_bit !== 1'b0 || run_cnt !== 4'd0 || hit_cnt !== 8'd0) begin
         fail_cnt++;
         $display("FAIL reset_state: out=%b bit=%b run=%0d hit=%0d, want 0 0 0 0", out, out_bit, run_cnt, hit_cnt);
      end
      mode_r = 2'b00; run_len_r = 4'd2;
      acc(1'b1); acc(1'b1); acc(1'b1);
      cmp_cnt++;
      if (run_cnt !== 4'd3 || hit_cnt !== 8'd1) begin
         fail_cnt++;
         $display("FAIL pre_reset_run: run=%0d hit=%0d, want 3 1", run_cnt, hit_cnt);
      end
      #2 reset_r = 1'b0;
      #1;
      cmp_cnt++;
      if (out !== 1'b0 || run_cnt !== 4'd0 || hit_cnt !== 8'd0 || out_bit !== 1'b0) begin
         fail_cnt++;
         $display("FAIL async_reset: out=%b run=%0d hit=%0d bit=%b, want 0 0 0 0", out, run_cnt, hit_cnt, out_bit);
      end
      tick(); tick();
      reset_r = 1'b1;
      acc(1'b0);
      cmp_cnt++;
      if (run_cnt !== 4'd1 || out_bit !== 1'b0 || out !== 1'b0) begin
         fail_cnt++;
         $display("FAIL post_reset_first: run=%0d bit=%b out=%b, want 1 0 0", run_cnt, out_bit, out);
      end
   endtask

   task automatic test_both_polarity();
      logic s[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic el[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic ep[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      int   er[6] = '{1, 2, 3, 4, 5, 1};
      do_clear(2'b00, 4'd4);
      for (int i = 0; i < 6; i++) begin
         acc(s[i]);
         cmp_cnt++;
         if (out !== (PULSE ? ep[i] : el[i]) || run_cnt !== 4'(er[i])) begin
            fail_cnt++;
            $display("FAIL both_run4[%0d]: out=%b run=%0d, want %b %0d", i, out, run_cnt, PULSE ? ep[i] : el[i], er[i]);
         end
      end
      cmp_cnt++;
      if (hit_cnt !== 8'd1) begin
         fail_cnt++;
         $display("FAIL both_run4_hits: got %0d want 1", hit_cnt);
      end
   endtask

   task automatic test_polarity_filter();
      logic s[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic e[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic z[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic ez[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      do_clear(2'b01, 4'd3);
      for (int i = 0; i < 7; i++) begin
         acc(s[i]);
         cmp_cnt++;
         if (out !== e[i]) begin
            fail_cnt++;
            $display("FAIL ones_only[%0d]: out=%b want %b", i, out, e[i]);
         end
      end
      cmp_cnt++;
      if (hit_cnt !== 8'd1) begin
         fail_cnt++;
         $display("FAIL ones_only_hits: got %0d want 1", hit_cnt);
      end
      do_clear(2'b10, 4'd2);
      for (int i = 0; i < 4; i++) begin
         acc(z[i]);
         cmp_cnt++;
         if (out !== ez[i]) begin
            fail_cnt++;
            $display("FAIL zeros_only[%0d]: out=%b want %b", i, out, ez[i]);
         end
      end
      mode_r = 2'b11;
      acc(1'b0);
      cmp_cnt++;
      if (out !== 1'b0 || run_cnt !== 4'd3) begin
         fail_cnt++;
         $display("FAIL mode_off: out=%b run=%0d want 0 3", out, run_cnt);
      end
      mode_r = 2'b00; run_len_r = 4'd0;
      acc(1'b0); acc(1'b0);
      cmp_cnt++;
      if (out !== 1'b0 || hit_cnt !== 8'd1) begin
         fail_cnt++;
         $display("FAIL runlen_zero: out=%b hit=%0d want 0 1", out, hit_cnt);
      end
   endtask

   task automatic test_saturation();
      logic eo;
      do_clear(2'b00, 4'd15);
      for (int i = 1; i <= 20; i++) begin
         acc(1'b1);
         eo = PULSE ? (i == 15) : (i >= 15);
         cmp_cnt++;
         if (run_cnt !== 4'((i > 15) ? 15 : i) || out !== eo) begin
            fail_cnt++;
            $display("FAIL saturate[%0d]: run=%0d out=%b want %0d %b", i, run_cnt, out, (i > 15) ? 15 : i, eo);
         end
      end
      cmp_cnt++;
      if (hit_cnt !== 8'd1) begin
         fail_cnt++;
         $display("FAIL saturate_hits: got %0d want 1", hit_cnt);
      end
   endtask

   task automatic test_gap_and_clear();
      do_clear(2'b00, 4'd2);
      acc(1'b1); acc(1'b1);
      cmp_cnt++;
      if (out !== 1'b1 || hit_cnt !== 8'd1) begin
         fail_cnt++;
         $display("FAIL gap_entry: out=%b hit=%0d want 1 1", out, hit_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         cmp_cnt++;
         if (out !== (PULSE ? 1'b0 : 1'b1) || run_cnt !== 4'd2 || hit_cnt !== 8'd1) begin
            fail_cnt++;
            $display("FAIL gap_hold[%0d]: out=%b run=%0d hit=%0d want %b 2 1", i, out, run_cnt, hit_cnt, ~PULSE);
         end
      end
      acc(1'b0);
      cmp_cnt++;
      if (out !== 1'b0 || run_cnt !== 4'd1) begin
         fail_cnt++;
         $display("FAIL gap_flip: out=%b run=%0d want 0 1", out, run_cnt);
      end
      acc(1'b0);
      cmp_cnt++;
      if (out !== 1'b1 || hit_cnt !== 8'd2) begin
         fail_cnt++;
         $display("FAIL gap_second: out=%b hit=%0d want 1 2", out, hit_cnt);
      end
      clear_r = 1'b1; in_r = 1'b1; in_valid_r = 1'b1;
      tick();
      clear_r = 1'b0; in_valid_r = 1'b0;
      cmp_cnt++;
      if (out !== 1'b0 || out_bit !== 1'b0 || run_cnt !== 4'd0 || hit_cnt !== 8'd0) begin
         fail_cnt++;
         $display("FAIL clear_prio: out=%b bit=%b run=%0d hit=%0d want 0 0 0 0", out, out_bit, run_cnt, hit_cnt);
      end
   endtask

   task automatic test_cfg_change();
      do_clear(2'b00, 4'd2);
      acc(1'b1); acc(1'b1);
      run_len_r = 4'd5; mode_r = 2'b11;
      tick(); tick();
      cmp_cnt++;
      if (out !== (PULSE ? 1'b0 : 1'b1)) begin
         fail_cnt++;
         $display("FAIL cfg_not_reeval: out=%b want %b", out, ~PULSE);
      end
      mode_r = 2'b00;
      acc(1'b1);
      cmp_cnt++;
      if (out !== 1'b0 || run_cnt !== 4'd3) begin
         fail_cnt++;
         $display("FAIL cfg_applied: out=%b run=%0d want 0 3", out, run_cnt);
      end
      acc(1'b1); acc(1'b1);
      cmp_cnt++;
      if (out !== 1'b1 || hit_cnt !== 8'd2) begin
         fail_cnt++;
         $display("FAIL cfg_reentry: out=%b hit=%0d want 1 2", out, hit_cnt);
      end
   endtask

   task automatic test_runlen1_both();
      logic s[3] = '{1'b1, 1'b0, 1'b1};
      logic ep[3] = '{1'b1, 1'b0, 1'b0};
      do_clear(2'b00, 4'd1);
      for (int i = 0; i < 3; i++) begin
         acc(s[i]);
         cmp_cnt++;
         if (out !== (PULSE ? ep[i] : 1'b1) || run_cnt !== 4'd1) begin
            fail_cnt++;
            $display("FAIL rl1_both[%0d]: out=%b run=%0d want %b 1", i, out, run_cnt, PULSE ? ep[i] : 1'b1);
         end
      end
      cmp_cnt++;
      if (hit_cnt !== 8'd1) begin
         fail_cnt++;
         $display("FAIL rl1_both_hits: got %0d want 1", hit_cnt);
      end
   endtask

   task automatic test_hit_saturation();
      do_clear(2'b01, 4'd1);
      for (int i = 0; i < 5; i++) begin
         acc(1'b1);
         cmp_cnt++;
         if (out2 !== 1'b1) begin
            fail_cnt++;
            $display("FAIL alt_one[%0d]: out=%b want 1", i, out2);
         end
         acc(1'b0);
      end
      cmp_cnt++;
      if (hit_cnt2 !== 2'd3 || hit_cnt !== 8'd5) begin
         fail_cnt++;
         $display("FAIL hit_saturate: hit2=%0d hit8=%0d want 3 5", hit_cnt2, hit_cnt);
      end
   endtask

   task automatic test_pulse();
      logic el[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      logic ep[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      do_clear(2'b00, 4'd2);
      for (int i = 0; i < 4; i++) begin
         acc(1'b1);
         cmp_cnt++;
         if (out !== (PULSE ? ep[i] : el[i])) begin
            fail_cnt++;
            $display("FAIL pulse_shape[%0d]: out=%b want %b", i, out, PULSE ? ep[i] : el[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_both_polarity();
      test_polarity_filter();
      test_saturation();
      test_gap_and_clear();
      test_cfg_change();
      test_runlen1_both();
      test_hit_saturation();
      test_pulse();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
      $finish;
   end

endmodule
